// File: rtl/snake_engine.sv
// rtl/snake_engine.sv - parametrised snake game engine
// Owns the snake body, direction lock, LFSR food placement and win/lose detection.
module snake_engine #(
   parameter int          COL_BITS  = 4,
   parameter int          ROW_BITS  = 4,
   parameter int          MAX_LEN   = 16,
   parameter bit          WRAP_MODE = 1'b0,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   localparam int         LOC_W     = ROW_BITS + COL_BITS,
   localparam int         LEN_W     = $clog2(MAX_LEN + 1)
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic                     Left,
   input  logic                     Right,
   input  logic                     Up,
   input  logic                     Down,
   input  logic                     Ack,
   input  logic                     Tick,
   output logic [4:0]               State,
   output logic [LOC_W-1:0]         Food,
   output logic [LEN_W-1:0]         Length,
   output logic [MAX_LEN*LOC_W-1:0] Locations_Flat
);
   localparam logic [4:0] S_INIT  = 5'b00001;
   localparam logic [4:0] S_PLACE = 5'b00010;
   localparam logic [4:0] S_RUN   = 5'b00100;
   localparam logic [4:0] S_WIN   = 5'b01000;
   localparam logic [4:0] S_LOSE  = 5'b10000;

   // Opposite directions differ only in bit 0.
   localparam logic [1:0] D_R = 2'd0;
   localparam logic [1:0] D_L = 2'd1;
   localparam logic [1:0] D_U = 2'd2;
   localparam logic [1:0] D_D = 2'd3;

   localparam logic [ROW_BITS-1:0] ROW_MID = ROW_BITS'(2 ** (ROW_BITS - 1));
   localparam logic [COL_BITS-1:0] COL_MID = COL_BITS'(2 ** (COL_BITS - 1));
   localparam logic [LOC_W-1:0]    HEAD0   = {ROW_MID, COL_MID};
   localparam logic [LOC_W-1:0]    SEG1    = {ROW_MID, COL_MID - COL_BITS'(1)};

   logic [4:0]          state, state_nx;
   logic [15:0]         lfsr;
   logic [1:0]          dir, pend, req, committed;
   logic                req_valid;
   logic [LOC_W-1:0]    seg [MAX_LEN];
   logic [LOC_W-1:0]    food, cand, nh;
   logic [LEN_W-1:0]    len, grow_len;
   logic [COL_BITS-1:0] hcol, ncol;
   logic [ROW_BITS-1:0] hrow, nrow;
   logic                off_edge, eat, collide, on_body, lose, move;

   assign hcol     = seg[0][COL_BITS-1:0];
   assign hrow     = seg[0][LOC_W-1:COL_BITS];
   assign nh       = {nrow, ncol};
   assign cand     = lfsr[LOC_W-1:0];
   assign eat      = (nh == food);
   assign grow_len = len + LEN_W'(1);
   assign lose     = (off_edge && !WRAP_MODE) || collide;
   assign move     = (state == S_RUN) && Tick && !lose;

   always_comb begin
      ncol     = hcol;
      nrow     = hrow;
      off_edge = 1'b0;
      case (pend)
         D_R:     begin ncol = hcol + COL_BITS'(1); off_edge = &hcol;  end
         D_L:     begin ncol = hcol - COL_BITS'(1); off_edge = ~|hcol; end
         D_U:     begin nrow = hrow - ROW_BITS'(1); off_edge = ~|hrow; end
         default: begin nrow = hrow + ROW_BITS'(1); off_edge = &hrow;  end
      endcase
   end

   // The tail cell is free on a plain move because the tail leaves it this tick.
   always_comb begin
      on_body = 1'b0;
      collide = 1'b0;
      for (int k = 0; k < MAX_LEN; k++) begin
         if (LEN_W'(k) < len && seg[k] == cand)
            on_body = 1'b1;
         if (seg[k] == nh && ((LEN_W'(k + 1) < len) || (eat && LEN_W'(k) < len)))
            collide = 1'b1;
      end
   end

   always_comb begin
      req_valid = Left | Right | Up | Down;
      req       = Left ? D_L : Right ? D_R : Up ? D_U : D_D;
      committed = move ? pend : dir;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= S_INIT;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_INIT:  if (Ack) state_nx = S_PLACE;
         S_PLACE: if (!on_body) state_nx = S_RUN;
         S_RUN: begin
            if (Tick) begin
               if (lose)     state_nx = S_LOSE;
               else if (eat) state_nx = (grow_len == LEN_W'(MAX_LEN)) ? S_WIN : S_PLACE;
            end
         end
         S_WIN, S_LOSE: if (Ack) state_nx = S_INIT;
         default: state_nx = S_INIT;
      endcase
   end

   always_comb begin
      State  = state;
      Food   = food;
      Length = len;
   end

   for (genvar g = 0; g < MAX_LEN; g++) begin : g_flat
      assign Locations_Flat[(MAX_LEN-g)*LOC_W-1 -: LOC_W] = seg[g];
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         lfsr <= LFSR_SEED;
         dir  <= D_R;
         pend <= D_R;
         food <= '0;
         len  <= '0;
         for (int k = 0; k < MAX_LEN; k++) seg[k] <= '0;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         if (req_valid && req != (committed ^ 2'b01)) pend <= req;
         if (move) dir <= pend;
         case (state)
            S_INIT: begin
               dir  <= D_R;
               pend <= D_R;
               len  <= LEN_W'(2);
               for (int k = 0; k < MAX_LEN; k++) seg[k] <= '0;
               seg[0] <= HEAD0;
               seg[1] <= SEG1;
            end
            S_PLACE: if (!on_body) food <= cand;
            S_RUN: begin
               if (move) begin
                  for (int k = 1; k < MAX_LEN; k++)
                     if (LEN_W'(k) < len || (eat && LEN_W'(k) == len)) seg[k] <= seg[k-1];
                  seg[0] <= nh;
                  if (eat) len <= grow_len;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_snake_engine.sv
// tb/tb_snake_engine.sv - directed bench for snake_engine
// Instance 0 bounds at the walls, instance 1 wraps; food is steered by timing Ack/Tick against an LFSR model.
module tb_snake_engine;
   localparam logic [4:0] S_INIT  = 5'b00001;
   localparam logic [4:0] S_PLACE = 5'b00010;
   localparam logic [4:0] S_RUN   = 5'b00100;
   localparam logic [4:0] S_WIN   = 5'b01000;
   localparam logic [4:0] S_LOSE  = 5'b10000;
   localparam int R = 0, L = 1, U = 2, D = 3;
   localparam int WAIT_MAX = 30000;

   logic         Clk;
   logic         rst_n;
   logic [1:0]   left, right, up, down, ack, tick;
   logic [4:0]   st [2];
   logic [7:0]   fd [2];
   logic [4:0]   ln [2];
   logic [127:0] fl [2];
   logic [15:0]  m;
   logic [15:0]  trig_m;
   int           checks, errors;

   snake_engine #(.WRAP_MODE(1'b0)) dut_n (
      .Clk(Clk), .Reset_n(rst_n), .Left(left[0]), .Right(right[0]), .Up(up[0]),
      .Down(down[0]), .Ack(ack[0]), .Tick(tick[0]), .State(st[0]), .Food(fd[0]),
      .Length(ln[0]), .Locations_Flat(fl[0]));

   snake_engine #(.WRAP_MODE(1'b1)) dut_w (
      .Clk(Clk), .Reset_n(rst_n), .Left(left[1]), .Right(right[1]), .Up(up[1]),
      .Down(down[1]), .Ack(ack[1]), .Tick(tick[1]), .State(st[1]), .Food(fd[1]),
      .Length(ln[1]), .Locations_Flat(fl[1]));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   always @(posedge Clk or negedge rst_n)
      if (!rst_n) m <= 16'hACE1;
      else        m <= lfsr_next(m);

   function automatic logic [7:0] seg_of(input int i, input int k);
      logic [127:0] f;
      f = fl[i];
      return f[(16-k)*8-1 -: 8];
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic press(input int i, input int d);
      case (d)
         R:       right[i] = 1'b1;
         L:       left[i]  = 1'b1;
         U:       up[i]    = 1'b1;
         default: down[i]  = 1'b1;
      endcase
      step();
      left[i] = 1'b0; right[i] = 1'b0; up[i] = 1'b0; down[i] = 1'b0;
   endtask

   task automatic do_tick(input int i);
      tick[i] = 1'b1;
      step();
      tick[i] = 1'b0;
   endtask

   // Pulse Ack or Tick on the cycle whose following PLACE evaluation sees candidate 'want'.
   task automatic trigger_at(input int i, input logic [7:0] want, input bit by_tick);
      logic [15:0] nx;
      int n;
      n  = 0;
      nx = lfsr_next(m);
      while (nx[7:0] != want && n < WAIT_MAX) begin
         step();
         n++;
         nx = lfsr_next(m);
      end
      chk("wait_bound", 128'(n < WAIT_MAX), 128'(1));
      trig_m = m;
      if (by_tick) tick[i] = 1'b1;
      else         ack[i]  = 1'b1;
      step();
      tick[i] = 1'b0;
      ack[i]  = 1'b0;
   endtask

   task automatic place(input int i, input logic [7:0] want, input bit by_tick, input string tag);
      trigger_at(i, want, by_tick);
      chk({tag, "_place"}, st[i], S_PLACE);
      step();
      chk({tag, "_food"}, fd[i], want);
      chk({tag, "_run"}, st[i], S_RUN);
   endtask

   initial begin
      logic [15:0] e1, e2;
      int n, c;
      checks = 0; errors = 0;
      left = '0; right = '0; up = '0; down = '0; ack = '0; tick = '0;
      rst_n = 1'b0;
      #12;
      chk("rst_state", st[0], S_INIT);
      chk("rst_len", ln[0], 0);
      chk("rst_flat", fl[0], 0);
      @(negedge Clk) rst_n = 1'b1;
      step();
      chk("init_len", ln[0], 2);
      chk("init_head", seg_of(0, 0), 8'h88);
      chk("init_seg1", seg_of(0, 1), 8'h87);

      // Basic move, reversal lock, turn
      place(0, 8'h6A, 1'b0, "n_start");
      do_tick(0);
      chk("t1_head", seg_of(0, 0), 8'h89);
      chk("t1_seg1", seg_of(0, 1), 8'h88);
      chk("t1_len", ln[0], 2);
      press(0, L);
      do_tick(0);
      chk("revlock_head", seg_of(0, 0), 8'h8A);
      press(0, U);
      do_tick(0);
      chk("up_head", seg_of(0, 0), 8'h7A);
      chk("up_seg1", seg_of(0, 1), 8'h8A);

      // Eat; first candidate lands on the body, so placement retries once
      trigger_at(0, 8'h7A, 1'b1);
      chk("eat_state", st[0], S_PLACE);
      chk("eat_len", ln[0], 3);
      chk("eat_head", seg_of(0, 0), 8'h6A);
      chk("eat_seg1", seg_of(0, 1), 8'h7A);
      chk("eat_tail", seg_of(0, 2), 8'h8A);
      step();
      chk("retry_state", st[0], S_PLACE);
      step();
      e1 = lfsr_next(trig_m);
      e2 = lfsr_next(e1);
      chk("retry_run", st[0], S_RUN);
      chk("retry_food", fd[0], e2[7:0]);
      chk("food_off_body", 128'(fd[0] == seg_of(0, 0) || fd[0] == seg_of(0, 1) || fd[0] == seg_of(0, 2)), 0);

      // Wall in bounded mode
      press(0, R);
      for (int k = 0; k < 5; k++) do_tick(0);
      chk("wall_pre", seg_of(0, 0), 8'h6F);
      do_tick(0);
      chk("wall_lose", st[0], S_LOSE);
      chk("wall_frozen", seg_of(0, 0), 8'h6F);
      chk("wall_len", ln[0], 3);
      ack[0] = 1'b1; step(); ack[0] = 1'b0;
      chk("lose_ack", st[0], S_INIT);
      step();
      chk("reinit_head", seg_of(0, 0), 8'h88);
      chk("reinit_rest", fl[0][111:0], 0);

      // Wrap instance: edge crossing, growth, tail chase, self-hit
      place(1, 8'h81, 1'b0, "w_start");
      for (int k = 0; k < 7; k++) do_tick(1);
      chk("w_pre", seg_of(1, 0), 8'h8F);
      do_tick(1);
      chk("wrap_head", seg_of(1, 0), 8'h80);
      chk("wrap_state", st[1], S_RUN);
      place(1, 8'h82, 1'b1, "w_eat1");
      place(1, 8'h91, 1'b1, "w_eat2");
      chk("w_len4", ln[1], 4);
      press(1, U); do_tick(1);
      press(1, L); do_tick(1);
      press(1, D); do_tick(1);
      chk("chase_head", seg_of(1, 0), 8'h81);
      chk("chase_tail", seg_of(1, 3), 8'h82);
      chk("chase_state", st[1], S_RUN);
      place(1, 8'h30, 1'b1, "w_eat3");
      chk("w_len5", ln[1], 5);
      press(1, R); do_tick(1);
      press(1, U); do_tick(1);
      press(1, L); do_tick(1);
      chk("selfhit_state", st[1], S_LOSE);
      chk("selfhit_head", seg_of(1, 0), 8'h82);
      chk("selfhit_len", ln[1], 5);
      ack[1] = 1'b1; step(); ack[1] = 1'b0;
      step();

      // Grow along row 8 to MAX_LEN
      place(1, 8'h89, 1'b0, "win_start");
      for (int k = 1; k <= 13; k++) begin
         c = (8 + k + 1) % 16;
         place(1, {4'h8, c[3:0]}, 1'b1, "grow");
         chk("grow_len", ln[1], 128'(2 + k));
      end
      do_tick(1);
      chk("win_state", st[1], S_WIN);
      chk("win_len", ln[1], 16);
      chk("win_head", seg_of(1, 0), 8'h86);
      chk("win_tail", seg_of(1, 15), 8'h87);
      do_tick(1);
      chk("win_frozen", seg_of(1, 0), 8'h86);
      ack[1] = 1'b1; step(); ack[1] = 1'b0;
      chk("win_ack", st[1], S_INIT);

      // Asynchronous reset in the middle of RUN
      ack[0] = 1'b1; step(); ack[0] = 1'b0;
      n = 0;
      while (st[0] != S_RUN && n < 100) begin step(); n++; end
      chk("pre_reset_run", st[0], S_RUN);
      #3 rst_n = 1'b0;
      #1;
      chk("async_state", st[0], S_INIT);
      chk("async_len", ln[0], 0);
      chk("async_food", fd[0], 0);
      chk("async_flat", fl[0], 0);
      #20;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
